// File: rtl/swd_xfer_sched.sv
// rtl/swd_xfer_sched.sv - SWD transfer scheduler: two-way round-robin, header build, WAIT retry, status response
module swd_xfer_sched #(
  parameter int RETRY_MAX   = 8,
  parameter int IDLE_CYCLES = 2
) (
  input  logic        sck,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_apndp,
  input  logic        req0_rnw,
  input  logic [1:0]  req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_apndp,
  input  logic        req1_rnw,
  input  logic [1:0]  req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        eng_start,
  output logic [7:0]  eng_req,
  output logic        eng_rnw,
  output logic [31:0] eng_wdata,
  input  logic        eng_done,
  input  logic [2:0]  eng_ack,
  input  logic [31:0] eng_rdata,
  input  logic        eng_rpar_err,
  output logic        rsp_valid,
  output logic        rsp_src,
  output logic [2:0]  rsp_status,
  output logic [2:0]  rsp_ack,
  output logic [31:0] rsp_rdata,
  output logic [3:0]  rsp_retries
);
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_BUSY, S_GAP_RETRY, S_RESP, S_GAP_END
  } state_t;

  localparam logic [3:0] RMAX     = 4'(RETRY_MAX);
  localparam logic [3:0] GAP_LAST = 4'(IDLE_CYCLES - 1);
  localparam logic [2:0] ST_OK = 3'd0, ST_WAIT_TO = 3'd1, ST_FAULT = 3'd2,
                         ST_PROTO = 3'd3, ST_PARITY = 3'd4;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        src_q, src_d;
  logic [7:0]  eng_req_q, eng_req_d;
  logic        eng_rnw_q, eng_rnw_d;
  logic [31:0] eng_wdata_q, eng_wdata_d;
  logic [3:0]  retries_q, retries_d;
  logic [3:0]  gap_q, gap_d;
  logic        rsp_src_q, rsp_src_d;
  logic [2:0]  rsp_status_q, rsp_status_d;
  logic [2:0]  rsp_ack_q, rsp_ack_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [3:0]  rsp_retries_q, rsp_retries_d;

  logic        grant0, grant1;
  logic        sel_apndp, sel_rnw;
  logic [1:0]  sel_addr;
  logic [31:0] sel_wdata;
  logic [7:0]  hdr;
  logic        term;
  logic [2:0]  term_status;
  logic [31:0] term_rdata;

  // last_grant_q resets to 1 so req0 takes the first tie
  assign grant0 = (state_q == S_IDLE) & req0_valid & (~req1_valid | last_grant_q);
  assign grant1 = (state_q == S_IDLE) & req1_valid & (~req0_valid | ~last_grant_q);

  assign sel_apndp = grant1 ? req1_apndp : req0_apndp;
  assign sel_rnw   = grant1 ? req1_rnw   : req0_rnw;
  assign sel_addr  = grant1 ? req1_addr  : req0_addr;
  assign sel_wdata = grant1 ? req1_wdata : req0_wdata;
  assign hdr = {1'b1, 1'b0, sel_apndp ^ sel_rnw ^ sel_addr[0] ^ sel_addr[1],
                sel_addr[1], sel_addr[0], sel_rnw, sel_apndp, 1'b1};

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    src_d         = src_q;
    eng_req_d     = eng_req_q;
    eng_rnw_d     = eng_rnw_q;
    eng_wdata_d   = eng_wdata_q;
    retries_d     = retries_q;
    gap_d         = gap_q;
    rsp_src_d     = rsp_src_q;
    rsp_status_d  = rsp_status_q;
    rsp_ack_d     = rsp_ack_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_retries_d = rsp_retries_q;
    term          = 1'b0;
    term_status   = ST_PROTO;
    term_rdata    = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (grant0 | grant1) begin
          src_d        = grant1;
          last_grant_d = grant1;
          eng_req_d    = hdr;
          eng_rnw_d    = sel_rnw;
          eng_wdata_d  = sel_wdata;
          retries_d    = 4'd0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_BUSY;
      S_BUSY: begin
        if (eng_done) begin
          term = 1'b1;
          case (eng_ack)
            3'b001: begin
              if (eng_rnw_q && eng_rpar_err) begin
                term_status = ST_PARITY;
              end else begin
                term_status = ST_OK;
                term_rdata  = eng_rnw_q ? eng_rdata : 32'd0;
              end
            end
            3'b010: begin
              if (retries_q < RMAX) begin
                term      = 1'b0;
                retries_d = retries_q + 4'd1;
                gap_d     = 4'd0;
                state_d   = S_GAP_RETRY;
              end else begin
                term_status = ST_WAIT_TO;
              end
            end
            3'b100:  term_status = ST_FAULT;
            default: term_status = ST_PROTO;
          endcase
          // rsp_* only move on a terminal outcome so they hold between responses
          if (term) begin
            rsp_src_d     = src_q;
            rsp_status_d  = term_status;
            rsp_ack_d     = eng_ack;
            rsp_rdata_d   = term_rdata;
            rsp_retries_d = retries_q;
            state_d       = S_RESP;
          end
        end
      end
      S_GAP_RETRY: begin
        if (gap_q == GAP_LAST) state_d = S_ISSUE;
        else gap_d = gap_q + 4'd1;
      end
      S_RESP: begin
        gap_d   = 4'd0;
        state_d = S_GAP_END;
      end
      S_GAP_END: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else gap_d = gap_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      src_q         <= 1'b0;
      eng_req_q     <= 8'h00;
      eng_rnw_q     <= 1'b0;
      eng_wdata_q   <= 32'd0;
      retries_q     <= 4'd0;
      gap_q         <= 4'd0;
      rsp_src_q     <= 1'b0;
      rsp_status_q  <= 3'd0;
      rsp_ack_q     <= 3'd0;
      rsp_rdata_q   <= 32'd0;
      rsp_retries_q <= 4'd0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      src_q         <= src_d;
      eng_req_q     <= eng_req_d;
      eng_rnw_q     <= eng_rnw_d;
      eng_wdata_q   <= eng_wdata_d;
      retries_q     <= retries_d;
      gap_q         <= gap_d;
      rsp_src_q     <= rsp_src_d;
      rsp_status_q  <= rsp_status_d;
      rsp_ack_q     <= rsp_ack_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_retries_q <= rsp_retries_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign eng_start   = (state_q == S_ISSUE);
  assign eng_req     = eng_req_q;
  assign eng_rnw     = eng_rnw_q;
  assign eng_wdata   = eng_wdata_q;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_src     = rsp_src_q;
  assign rsp_status  = rsp_status_q;
  assign rsp_ack     = rsp_ack_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_retries = rsp_retries_q;
endmodule

// File: tb/tb_swd_xfer_sched.sv
// tb/tb_swd_xfer_sched.sv - directed vector bench for swd_xfer_sched
module tb_swd_xfer_sched;
  localparam int IDLE = 2;

  logic        sck = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_apndp, req0_rnw;
  logic [1:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic        req1_valid, req1_ready, req1_apndp, req1_rnw;
  logic [1:0]  req1_addr;
  logic [31:0] req1_wdata;
  logic        eng_start, eng_rnw, eng_done, eng_rpar_err;
  logic [7:0]  eng_req;
  logic [31:0] eng_wdata, eng_rdata;
  logic [2:0]  eng_ack;
  logic        rsp_valid, rsp_src;
  logic [2:0]  rsp_status, rsp_ack;
  logic [31:0] rsp_rdata;
  logic [3:0]  rsp_retries;

  int total = 0;
  int bad = 0;
  int n_start = 0;
  int n_rsp = 0;
  int both_rdy = 0;

  swd_xfer_sched #(.RETRY_MAX(8), .IDLE_CYCLES(IDLE)) dut (
    .sck(sck), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_apndp(req0_apndp),
    .req0_rnw(req0_rnw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_apndp(req1_apndp),
    .req1_rnw(req1_rnw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .eng_start(eng_start), .eng_req(eng_req), .eng_rnw(eng_rnw), .eng_wdata(eng_wdata),
    .eng_done(eng_done), .eng_ack(eng_ack), .eng_rdata(eng_rdata), .eng_rpar_err(eng_rpar_err),
    .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_status(rsp_status), .rsp_ack(rsp_ack),
    .rsp_rdata(rsp_rdata), .rsp_retries(rsp_retries)
  );

  always #5 sck = ~sck;

  always @(negedge sck) begin
    if (eng_start) n_start++;
    if (rsp_valid) n_rsp++;
    if (req0_ready && req1_ready) both_rdy++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        src;
    logic        apndp;
    logic        rnw;
    logic [1:0]  addr;
    logic [31:0] wdata;
    int          nwait;
    logic [2:0]  fack;
    logic [31:0] erdata;
    logic        perr;
    logic [7:0]  x_req;
    logic [2:0]  x_status;
    logic [31:0] x_rdata;
    logic [3:0]  x_retries;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic src, input logic apndp, input logic rnw,
                              input logic [1:0] addr, input logic [31:0] wdata,
                              input int nwait, input logic [2:0] fack,
                              input logic [31:0] erdata, input logic perr,
                              input logic [7:0] x_req, input logic [2:0] x_status,
                              input logic [31:0] x_rdata, input logic [3:0] x_retries);
    vec_t v;
    v.src = src; v.apndp = apndp; v.rnw = rnw; v.addr = addr; v.wdata = wdata;
    v.nwait = nwait; v.fack = fack; v.erdata = erdata; v.perr = perr;
    v.x_req = x_req; v.x_status = x_status; v.x_rdata = x_rdata; v.x_retries = x_retries;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge sck); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge sck);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_start"}, 32'(eng_start), 32'd0);
    chk({tag, "_req"}, 32'(eng_req), 32'h00);
    chk({tag, "_rnw"}, 32'(eng_rnw), 32'd0);
    chk({tag, "_wdata"}, eng_wdata, 32'd0);
    chk({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_fields"},
        32'({rsp_src, rsp_status, rsp_ack, rsp_retries}) | rsp_rdata, 32'd0);
    chk({tag, "_ready"}, 32'({req0_ready, req1_ready}), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit got;
    int k, s0, r0;
    string t;
    t = $sformatf("v%0d", idx);
    s0 = n_start;
    r0 = n_rsp;
    @(posedge sck); #1;
    req0_apndp = v.apndp; req0_rnw = v.rnw; req0_addr = v.addr; req0_wdata = v.wdata;
    req1_apndp = v.apndp; req1_rnw = v.rnw; req1_addr = v.addr; req1_wdata = v.wdata;
    req0_valid = (v.src == 1'b0);
    req1_valid = (v.src == 1'b1);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge sck);
      got = v.src ? req1_ready : req0_ready;
    end
    chk({t, "_accept"}, 32'(got), 32'd1);
    @(posedge sck); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!got) return;
    @(negedge sck);
    for (int a = 0; a <= v.nwait; a++) begin
      chk($sformatf("%s_a%0d_start", t, a), 32'(eng_start), 32'd1);
      chk($sformatf("%s_a%0d_req", t, a), 32'(eng_req), 32'(v.x_req));
      chk($sformatf("%s_a%0d_wdata", t, a), eng_wdata, v.wdata);
      chk($sformatf("%s_a%0d_rnw", t, a), 32'(eng_rnw), 32'(v.rnw));
      repeat (2) @(posedge sck);
      #1;
      eng_done = 1'b1;
      eng_ack = (a < v.nwait) ? 3'b010 : v.fack;
      eng_rdata = v.erdata;
      eng_rpar_err = v.perr;
      @(posedge sck); #1;
      eng_done = 1'b0; eng_ack = 3'b000; eng_rdata = 32'd0; eng_rpar_err = 1'b0;
      if (a < v.nwait) begin
        got = 0;
        k = 0;
        for (int i = 1; i <= IDLE + 6 && !got; i++) begin
          @(negedge sck);
          if (eng_start) begin
            got = 1;
            k = i;
          end
        end
        chk($sformatf("%s_a%0d_gap", t, a), 32'(k), 32'(IDLE + 1));
        if (!got) return;
      end
    end
    @(negedge sck);
    chk({t, "_rspv"}, 32'(rsp_valid), 32'd1);
    chk({t, "_src"}, 32'(rsp_src), 32'(v.src));
    chk({t, "_status"}, 32'(rsp_status), 32'(v.x_status));
    chk({t, "_ack"}, 32'(rsp_ack), 32'(v.fack));
    chk({t, "_rdata"}, rsp_rdata, v.x_rdata);
    chk({t, "_retries"}, 32'(rsp_retries), 32'(v.x_retries));
    @(negedge sck);
    chk({t, "_rspv_pulse"}, 32'(rsp_valid), 32'd0);
    chk({t, "_nstart"}, 32'(n_start - s0), 32'(v.nwait + 1));
    chk({t, "_nrsp"}, 32'(n_rsp - r0), 32'd1);
  endtask

  initial begin
    bit got, have;
    int k, r0, s0, bad_seen;

    rst_n = 1'b0;
    req0_valid = 0; req0_apndp = 0; req0_rnw = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_apndp = 0; req1_rnw = 0; req1_addr = 0; req1_wdata = 0;
    eng_done = 0; eng_ack = 0; eng_rdata = 0; eng_rpar_err = 0;

    //        src ap rnw addr wdata        nw  fack    erdata        pe  x_req  x_st  x_rdata       x_ret
    vecs[0] = mk(0, 0, 1, 2'd0, 32'h0,        0, 3'b001, 32'h0BA01477, 0, 8'hA5, 3'd0, 32'h0BA01477, 4'd0);
    vecs[1] = mk(1, 1, 0, 2'd3, 32'hDEADBEEF, 2, 3'b001, 32'h12345678, 0, 8'hBB, 3'd0, 32'h0,        4'd2);
    vecs[2] = mk(1, 1, 0, 2'd3, 32'hDEADBEEF, 8, 3'b010, 32'h0,        0, 8'hBB, 3'd1, 32'h0,        4'd8);
    vecs[3] = mk(0, 0, 0, 2'd0, 32'h00000001, 0, 3'b100, 32'h0,        0, 8'h81, 3'd2, 32'h0,        4'd0);
    vecs[4] = mk(0, 0, 0, 2'd0, 32'h00000001, 0, 3'b111, 32'h0,        0, 8'h81, 3'd3, 32'h0,        4'd0);
    vecs[5] = mk(0, 0, 1, 2'd0, 32'h0,        0, 3'b001, 32'hCAFEF00D, 1, 8'hA5, 3'd4, 32'h0,        4'd0);
    vecs[6] = mk(1, 1, 1, 2'd1, 32'h0,        1, 3'b001, 32'h55AA0001, 0, 8'hAF, 3'd0, 32'h55AA0001, 4'd1);
    vecs[7] = mk(1, 0, 1, 2'd2, 32'h0,        0, 3'b000, 32'h77777777, 0, 8'h95, 3'd3, 32'h0,        4'd0);

    repeat (2) @(negedge sck);
    check_idle_outputs("reset");
    @(posedge sck); #1 rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // round-robin with both requesters held valid
    do_reset();
    req0_apndp = 0; req0_rnw = 1; req0_addr = 2'd1; req0_wdata = 32'h0;
    req1_apndp = 0; req1_rnw = 0; req1_addr = 2'd2; req1_wdata = 32'hA5A5A5A5;
    r0 = n_rsp;
    @(posedge sck); #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    have = 0;
    for (int t = 0; t < 4; t++) begin
      if (!have) begin
        for (int i = 0; i < 40 && !have; i++) begin
          @(negedge sck);
          have = req0_ready | req1_ready;
        end
      end
      chk($sformatf("rr%0d_ready", t), 32'(have), 32'd1);
      if (!have) break;
      chk($sformatf("rr%0d_order", t), 32'(req1_ready), 32'(t % 2));
      @(negedge sck);
      chk($sformatf("rr%0d_start", t), 32'(eng_start), 32'd1);
      repeat (2) @(posedge sck);
      #1;
      eng_done = 1'b1; eng_ack = 3'b001; eng_rdata = 32'h100 + 32'(t);
      @(posedge sck); #1;
      eng_done = 1'b0; eng_ack = 3'b000; eng_rdata = 32'd0;
      @(negedge sck);
      chk($sformatf("rr%0d_rspv", t), 32'(rsp_valid), 32'd1);
      chk($sformatf("rr%0d_src", t), 32'(rsp_src), 32'(t % 2));
      chk($sformatf("rr%0d_rdata", t), rsp_rdata, (t % 2) ? 32'd0 : 32'h100 + 32'(t));
      have = 0;
      if (t < 3) begin
        k = 0;
        for (int i = 1; i <= IDLE + 6 && !have; i++) begin
          @(negedge sck);
          if (req0_ready | req1_ready) begin
            have = 1;
            k = i;
          end
        end
        chk($sformatf("rr%0d_gap", t), 32'(k), 32'(IDLE + 1));
      end
    end
    @(posedge sck); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (IDLE + 2) @(negedge sck);
    chk("rr_nrsp", 32'(n_rsp - r0), 32'd4);

    // reset while BUSY, then a stray eng_done
    @(posedge sck); #1;
    req0_apndp = 0; req0_rnw = 0; req0_addr = 2'd0; req0_wdata = 32'h13579BDF;
    req0_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge sck);
      got = req0_ready;
    end
    chk("rstb_accept", 32'(got), 32'd1);
    @(posedge sck); #1 req0_valid = 1'b0;
    @(negedge sck);
    chk("rstb_start", 32'(eng_start), 32'd1);
    @(posedge sck); #2 rst_n = 1'b0;
    @(negedge sck);
    check_idle_outputs("rstb");
    @(posedge sck); #1 rst_n = 1'b1;
    r0 = n_rsp;
    s0 = n_start;
    eng_done = 1'b1; eng_ack = 3'b001;
    @(posedge sck); #1;
    eng_done = 1'b0; eng_ack = 3'b000;
    bad_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sck);
      if (eng_start || rsp_valid || eng_req != 8'h00) bad_seen++;
    end
    chk("rstb_quiet", 32'(bad_seen), 32'd0);
    chk("rstb_nrsp", 32'(n_rsp - r0), 32'd0);
    chk("rstb_nstart", 32'(n_start - s0), 32'd0);
    run_vec(vecs[0], 10);

    chk("never_both_ready", 32'(both_rdy), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/swd_xfer_sched.md
# swd_xfer_sched

SWD transfer scheduler between the host command path and the SWD line engine (the block driving `swclk`/`swdio`). It arbitrates between two requesters and builds the 8-bit SWD request header. It issues one transfer at a time to the engine, retries on WAIT ACK up to a limit, and returns one status-tagged response per accepted request. All sequencing is in the `sck` domain.

## Interface
- `RETRY_MAX`, 8: maximum re-issues after WAIT ACK; legal range 0..15.
- `IDLE_CYCLES`, 2: idle `sck` cycles inserted after every transfer attempt; legal range 1..15.

Ports (reqN = req0, req1):
- `sck` in 1: single clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `reqN_valid` in 1: requester N holds a transfer.
- `reqN_ready` out 1: acceptance strobe; transfer taken when `reqN_valid & reqN_ready`.
- `reqN_apndp` in 1: 1 = AP, 0 = DP.
- `reqN_rnw` in 1: 1 = read, 0 = write.
- `reqN_addr` in 2: A[3:2].
- `reqN_wdata` in 32: write data.
- `eng_start` out 1: one-cycle pulse launching an engine transfer.
- `eng_req` out 8: request header, sent LSB first.
- `eng_rnw` out 1: direction of current transfer.
- `eng_wdata` out 32: write data.
- `eng_done` in 1: one-cycle pulse; the engine has finished the transfer.
- `eng_ack` in 3: ACK bits, first-received bit in bit 0.
- `eng_rdata` in 32: read data, valid with `eng_done`.
- `eng_rpar_err` in 1: read parity mismatch, valid with `eng_done`.
- `rsp_valid` out 1: one-cycle response pulse; no backpressure.
- `rsp_src` out 1: requester index.
- `rsp_status` out 3: 0 OK, 1 WAIT_TIMEOUT, 2 FAULT, 3 PROTO, 4 PARITY.
- `rsp_ack` out 3: last raw ACK.
- `rsp_rdata` out 32: read data; 0 for writes and for non-OK status.
- `rsp_retries` out 4: number of re-issues performed.

## Operation
- States: IDLE, ISSUE, BUSY, GAP_RETRY, RESP, GAP_END.
- IDLE: `reqN_ready` = IDLE & grantN (combinational).
  - Round-robin grant: if both requesters are valid, grant the one not granted last. The last-grant pointer resets so that req0 wins the first tie.
  - On accept: latch fields and src, clear the retry counter, go to ISSUE.
- Header: bit0 = 1 (start), bit1 = APnDP, bit2 = RnW, bit3 = A2, bit4 = A3, bit5 = XOR(bit1..bit4), bit6 = 0 (stop), bit7 = 1 (park).
- ISSUE: `eng_start` = 1 for exactly one cycle, then BUSY. `eng_req`/`eng_rnw`/`eng_wdata` are registered and stable from ISSUE until the next accept.
- BUSY: wait for `eng_done`. `eng_done` in any other state is ignored. On `eng_done`, evaluate `eng_ack`:
  - 001 with write, or read with `eng_rpar_err` = 0: status OK → RESP.
  - 001 with read and `eng_rpar_err` = 1: status PARITY → RESP. No retry.
  - 010 with retries < RETRY_MAX: increment retries → GAP_RETRY.
  - 010 with retries = RETRY_MAX: status WAIT_TIMEOUT → RESP.
  - 100: status FAULT → RESP. No retry.
  - Any other value: status PROTO → RESP.
- GAP_RETRY: count IDLE_CYCLES cycles, then ISSUE.
- RESP: `rsp_valid` for one cycle, then GAP_END.
- GAP_END: count IDLE_CYCLES cycles, then IDLE.
- `rsp_*` fields hold their value until the next `rsp_valid`.

## Timing
- Reset values: all outputs 0, except `eng_req` = 0x00. State is IDLE, counters are 0, any pending transfer is dropped, and no response is produced.
- Reset asserted in BUSY: `eng_start` stays 0. Any `eng_done` after release is ignored until the next ISSUE.
- Accept in cycle N → `eng_start` high in cycle N+1.
- `eng_done` in cycle D:
  - Terminal ACK: `rsp_valid` in D+1; next `reqN_ready` no earlier than D+2+IDLE_CYCLES.
  - WAIT with retry: next `eng_start` in D+1+IDLE_CYCLES.
- Total attempts per request ≤ RETRY_MAX+1.
- `reqN_ready` is never high outside IDLE, and never high for both requesters in the same cycle.

## Test plan
- DP read addr 0 from req0; engine returns ACK 001, rdata 0x0BA01477, parity ok → `eng_req` = 0xA5; one start; rsp src 0, status OK, rdata 0x0BA01477, retries 0.
- AP write addr 3, wdata 0xDEADBEEF from req1; ACKs 010, 010, 001 → `eng_req` = 0xBB; three starts each IDLE_CYCLES+1 cycles after the previous done; `eng_wdata` stable throughout; rsp status OK, retries 2, rdata 0.
- Same request with ACK always 010, RETRY_MAX = 8 → nine starts; rsp status WAIT_TIMEOUT, retries 8, ack 010.
- DP write addr 0 with ACK 100 → `eng_req` = 0x81; one start; status FAULT. Repeat with ACK 111 → status PROTO. Repeat as a read with ACK 001 and `eng_rpar_err` = 1 → status PARITY, rdata 0.
- Both requesters valid continuously for four transfers → grant order 0,1,0,1; exactly one response per accept, with matching `rsp_src`.
- `rst_n` pulsed low during BUSY, then `eng_done` arrives → all outputs 0, no `rsp_valid`; the next accept proceeds normally.
